// File: rtl/clb_loader_if.sv
// System-bus link between the coefficient loader (master) and the calibration block slave port.
// One strobe per transaction; the slave finishes it with ack and/or err.
interface clb_loader_if #(
    parameter int AW = 32
);
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_wen;
    logic          bus_ren;
    logic [31:0]   bus_rdata;
    logic          bus_ack;
    logic          bus_err;

    modport master (
        output bus_addr, bus_wdata, bus_wen, bus_ren,
        input  bus_rdata, bus_ack, bus_err
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_wen, bus_ren,
        output bus_rdata, bus_ack, bus_err
    );
endinterface

// File: rtl/clb_loader.sv
// Writes the snapshotted DAC/ADC gain/offset set to the calibration block, then optionally reads it back.
// Two cycles per transaction with a next-cycle ack; waits up to TMO cycles per ack before aborting.
module clb_loader #(
    parameter int          MNG    = 2,
    parameter int          MNO    = 2,
    parameter int          DWG    = 14,
    parameter int          DWO    = 16,
    parameter int          AW     = 32,
    parameter int unsigned BASE   = 0,
    parameter int          TMO    = 255,
    parameter int          VERIFY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MNG*DWG-1:0]   cfg_dac_mul,
    input  logic [MNG*DWG-1:0]   cfg_dac_sum,
    input  logic [MNO*DWO-1:0]   cfg_adc_mul,
    input  logic [MNO*DWO-1:0]   cfg_adc_sum,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [1:0]           fail_code,
    output logic [7:0]           fail_idx,
    clb_loader_if.master         bus
);

    localparam int N  = 2 * (MNG + MNO);
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_WAIT = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [7:0]         k_q, k_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic               busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic [1:0]         code_q, code_d;
    logic [7:0]         idx_q, idx_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               wen_q, wen_d, ren_q, ren_d;
    logic [MNG*DWG-1:0] dmul_q, dmul_d, dsum_q, dsum_d;
    logic [MNO*DWO-1:0] amul_q, amul_d, asum_q, asum_d;
    logic               abort;
    logic [1:0]         abort_code;

    function automatic logic [31:0] coef_word(input logic [7:0] k,
                                              input logic [MNG*DWG-1:0] dmul, dsum,
                                              input logic [MNO*DWO-1:0] amul, asum);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < MNG; i++) begin
            if (k == 8'(2*i))   w = 32'($signed(dmul[i*DWG +: DWG]));
            if (k == 8'(2*i+1)) w = 32'($signed(dsum[i*DWG +: DWG]));
        end
        for (int i = 0; i < MNO; i++) begin
            if (k == 8'(2*MNG+2*i))   w = 32'($signed(amul[i*DWO +: DWO]));
            if (k == 8'(2*MNG+2*i+1)) w = 32'($signed(asum[i*DWO +: DWO]));
        end
        return w;
    endfunction

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        tmr_d      = tmr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        fail_d     = fail_q;
        code_d     = code_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dmul_d     = dmul_q;
        dsum_d     = dsum_q;
        amul_d     = amul_q;
        asum_d     = asum_q;
        abort      = 1'b0;
        abort_code = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dmul_d  = cfg_dac_mul;
                    dsum_d  = cfg_dac_sum;
                    amul_d  = cfg_adc_mul;
                    asum_d  = cfg_adc_sum;
                    k_d     = 8'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                    code_d  = 2'd0;
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                tmr_d   = '0;
                state_d = S_WR_WAIT;
            end
            S_RD_REQ: begin
                tmr_d   = '0;
                state_d = S_RD_WAIT;
            end
            S_WR_WAIT, S_RD_WAIT: begin
                // err outranks both a readback mismatch and a plain ack
                if (bus.bus_err) begin
                    abort      = 1'b1;
                    abort_code = 2'd1;
                end else if (bus.bus_ack) begin
                    if (state_q == S_RD_WAIT && bus.bus_rdata != wdata_q) begin
                        abort      = 1'b1;
                        abort_code = 2'd3;
                    end else if (k_q != 8'(N-1)) begin
                        k_d     = k_q + 8'd1;
                        state_d = (state_q == S_WR_WAIT) ? S_WR_REQ : S_RD_REQ;
                    end else if (state_q == S_WR_WAIT && VERIFY != 0) begin
                        k_d     = 8'd0;
                        state_d = S_RD_REQ;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (tmr_q == TW'(TMO-1)) begin
                    abort      = 1'b1;
                    abort_code = 2'd2;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            busy_d  = 1'b0;
            fail_d  = 1'b1;
            done_d  = 1'b0;
            code_d  = abort_code;
            idx_d   = k_q;
            state_d = S_IDLE;
        end

        // Strobes and bus payload are registered on entry to a REQ state so they line up with it
        wen_d = (state_d == S_WR_REQ);
        ren_d = (state_d == S_RD_REQ);
        if (wen_d || ren_d) begin
            addr_d  = AW'(BASE) + (AW'(k_d) << 2);
            wdata_d = coef_word(k_d, dmul_d, dsum_d, amul_d, asum_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            tmr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            dmul_q  <= '0;
            dsum_q  <= '0;
            amul_q  <= '0;
            asum_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tmr_q   <= tmr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
            dmul_q  <= dmul_d;
            dsum_q  <= dsum_d;
            amul_q  <= amul_d;
            asum_q  <= asum_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign fail          = fail_q;
    assign fail_code     = code_q;
    assign fail_idx      = idx_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_wen   = wen_q;
    assign bus.bus_ren   = ren_q;

endmodule

// File: tb/tb_clb_loader.sv
// Bench for clb_loader: table vectors, hand sequences and random runs against a transaction-level model.
module tb_clb_loader;
    localparam int TMO = 10;
    localparam int N   = 8;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [27:0] cfg_dm, cfg_ds;
    logic [31:0] cfg_am, cfg_as;
    logic        busy, done, fail;
    logic [1:0]  fail_code;
    logic [7:0]  fail_idx;

    clb_loader_if #(.AW(32)) bus();

    clb_loader #(.MNG(2), .MNO(2), .DWG(14), .DWO(16), .AW(32), .BASE(0), .TMO(TMO), .VERIFY(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_dac_mul(cfg_dm), .cfg_dac_sum(cfg_ds), .cfg_adc_mul(cfg_am), .cfg_adc_sum(cfg_as),
        .busy(busy), .done(done), .fail(fail), .fail_code(fail_code), .fail_idx(fail_idx),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int strobes = 0;
    int overlap = 0;
    logic [63:0] wlog[$];
    logic [31:0] rlog[$];
    logic [63:0] exp_w[$];
    logic [31:0] exp_r[$];

    // fault kinds: 0 none, 1 err on write k, 2 err on read k, 3 read k returns 0, 4 no ack write k, 5 no ack read k
    int          fault_kind = 0;
    int          fault_k    = 0;
    logic        slave_off  = 1'b0;
    logic        force_ack  = 1'b0;
    logic        pend = 1'b0, pend_wr = 1'b0;
    logic [31:0] pend_addr = '0, pend_wdata = '0;
    logic [31:0] mem [0:7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.bus_wen) begin wlog.push_back({bus.bus_addr, bus.bus_wdata}); strobes++; end
        if (bus.bus_ren) begin rlog.push_back(bus.bus_addr); strobes++; end
        if (bus.bus_wen && bus.bus_ren) overlap++;
    end

    // Responder: acks during the cycle after each strobe unless a fault says otherwise
    always @(negedge clk) begin
        logic [2:0] sidx;
        logic       hit;
        if (slave_off) begin
            bus.bus_ack   = force_ack;
            bus.bus_err   = 1'b0;
            bus.bus_rdata = 32'h0;
        end else begin
            bus.bus_ack   = 1'b0;
            bus.bus_err   = 1'b0;
            bus.bus_rdata = $urandom;
            if (pend) begin
                sidx = pend_addr[4:2];
                hit  = (int'(sidx) == fault_k);
                if (!(hit && ((pend_wr && fault_kind == 4) || (!pend_wr && fault_kind == 5)))) begin
                    bus.bus_ack = 1'b1;
                    bus.bus_err = hit && ((pend_wr && fault_kind == 1) || (!pend_wr && fault_kind == 2));
                    if (pend_wr) mem[sidx] = pend_wdata;
                    else bus.bus_rdata = (hit && fault_kind == 3) ? 32'h0 : mem[sidx];
                end
            end
            pend       = bus.bus_wen | bus.bus_ren;
            pend_wr    = bus.bus_wen;
            pend_addr  = bus.bus_addr;
            pend_wdata = bus.bus_wdata;
        end
    end

    function automatic logic [31:0] ref_word(input int k, input logic [27:0] dm, ds, input logic [31:0] am, asv);
        logic signed [13:0] g;
        logic signed [15:0] o;
        int v;
        if (k < 4) begin
            g = (k % 2 == 0) ? dm[(k/2)*14 +: 14] : ds[(k/2)*14 +: 14];
            v = g;
        end else begin
            o = (k % 2 == 0) ? am[((k-4)/2)*16 +: 16] : asv[((k-4)/2)*16 +: 16];
            v = o;
        end
        return v;
    endfunction

    task automatic model(input logic [27:0] dm, ds, input logic [31:0] am, asv, input int fk, fkk,
                         output logic edone, output logic [1:0] ecode, output logic [7:0] eidx, output int ecyc);
        logic        stop;
        logic        hit;
        logic [31:0] w;
        exp_w.delete();
        exp_r.delete();
        edone = 1'b1; ecode = 2'd0; eidx = 8'd0; ecyc = 0; stop = 1'b0;
        for (int p = 0; p < 2 && !stop; p++) begin
            for (int k = 0; k < N && !stop; k++) begin
                w = ref_word(k, dm, ds, am, asv);
                if (p == 0) exp_w.push_back({32'(4*k), w});
                else        exp_r.push_back(32'(4*k));
                hit = (fkk == k) && ((p == 0 && (fk == 1 || fk == 4)) || (p == 1 && (fk == 2 || fk == 3 || fk == 5)));
                if (hit && fk == 3 && w == 32'h0) hit = 1'b0;
                if (hit) begin
                    stop  = 1'b1;
                    edone = 1'b0;
                    eidx  = 8'(k);
                    ecode = (fk == 4 || fk == 5) ? 2'd2 : ((fk == 3) ? 2'd3 : 2'd1);
                    ecyc += (ecode == 2'd2) ? 1 + TMO : 2;
                end else begin
                    ecyc += 2;
                end
            end
        end
    endtask

    task automatic run_one(input string nm, input logic [27:0] dm, ds, input logic [31:0] am, asv,
                           input int fk, fkk, restart, input logic edone, input logic [1:0] ecode, input logic [7:0] eidx);
        logic       mdone;
        logic [1:0] mcode;
        logic [7:0] midx;
        int         ecyc, nb, cyc;
        model(dm, ds, am, asv, fk, fkk, mdone, mcode, midx, ecyc);
        fault_kind = fk;
        fault_k    = fkk;
        cfg_dm = dm; cfg_ds = ds; cfg_am = am; cfg_as = asv;
        wlog.delete();
        rlog.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cfg_dm = ~dm; cfg_ds = ~ds; cfg_am = ~am; cfg_as = ~asv;
        nb = 0; cyc = 0;
        while (cyc < 3000 && (busy || !(done || fail))) begin
            if (busy) nb++;
            start = (cyc == restart);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({nm, "_bound"}, 64'(cyc < 3000), 64'd1);
        chk({nm, "_done"},  64'(done), 64'(edone));
        chk({nm, "_fail"},  64'(fail), 64'(!edone));
        chk({nm, "_code"},  64'(fail_code), 64'(ecode));
        if (!edone) chk({nm, "_idx"}, 64'(fail_idx), 64'(eidx));
        chk({nm, "_busycyc"}, 64'(nb), 64'(ecyc));
        chk({nm, "_nwr"}, 64'(wlog.size()), 64'(exp_w.size()));
        chk({nm, "_nrd"}, 64'(rlog.size()), 64'(exp_r.size()));
        for (int i = 0; i < exp_w.size() && i < wlog.size(); i++)
            chk($sformatf("%s_wr%0d", nm, i), wlog[i], exp_w[i]);
        for (int i = 0; i < exp_r.size() && i < rlog.size(); i++)
            chk($sformatf("%s_rd%0d", nm, i), 64'(rlog[i]), 64'(exp_r[i]));
    endtask

    typedef struct {
        logic [27:0] dm;
        logic [27:0] ds;
        logic [31:0] am;
        logic [31:0] asv;
        int          fk;
        int          fkk;
        logic        edone;
        logic [1:0]  ecode;
        logic [7:0]  eidx;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic       rdone;
        logic [1:0] rcode;
        logic [7:0] ridx;
        int         rcyc, s0;
        logic       found;
        logic [27:0] dm, ds;
        logic [31:0] am, asv;
        int          fk, fkk;

        vecs[0] = '{{14'h0123, 14'h1000}, {14'h3FFF, 14'h0042}, {16'h7FFF, 16'h1234}, {16'h00AA, 16'h5555}, 0, 0, 1'b1, 2'd0, 8'd0};
        vecs[1] = '{{14'h2000, 14'h0001}, {14'h1555, 14'h2AAA}, {16'hFFFF, 16'h0000}, {16'h8000, 16'h7FFF}, 0, 0, 1'b1, 2'd0, 8'd0};
        vecs[2] = '{{14'h0123, 14'h1000}, {14'h3FFF, 14'h0042}, {16'h7FFF, 16'h1234}, {16'h00AA, 16'h5555}, 3, 3, 1'b0, 2'd3, 8'd3};
        vecs[3] = '{{14'h0123, 14'h1000}, {14'h3FFF, 14'h0042}, {16'h7FFF, 16'h1234}, {16'h00AA, 16'h5555}, 1, 5, 1'b0, 2'd1, 8'd5};
        vecs[4] = '{{14'h0123, 14'h1000}, {14'h3FFF, 14'h0042}, {16'h7FFF, 16'h1234}, {16'h00AA, 16'h5555}, 4, 0, 1'b0, 2'd2, 8'd0};
        vecs[5] = '{{14'h0123, 14'h1000}, {14'h3FFF, 14'h0042}, {16'h7FFF, 16'h1234}, {16'h00AA, 16'h5555}, 0, 0, 1'b1, 2'd0, 8'd0};
        vecs[6] = '{{14'h0ACE, 14'h3001}, {14'h0777, 14'h2222}, {16'hC001, 16'h0F0F}, {16'h4321, 16'hABCD}, 2, 6, 1'b0, 2'd1, 8'd6};
        vecs[7] = '{{14'h0ACE, 14'h3001}, {14'h0777, 14'h2222}, {16'hC001, 16'h0F0F}, {16'h4321, 16'hABCD}, 5, 7, 1'b0, 2'd2, 8'd7};

        rst = 1'b1; start = 1'b0;
        cfg_dm = '0; cfg_ds = '0; cfg_am = '0; cfg_as = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fail", 64'(fail), 64'd0);
        chk("rst_code_idx", 64'({fail_code, fail_idx}), 64'd0);
        chk("rst_strobes", 64'({bus.bus_wen, bus.bus_ren}), 64'd0);
        chk("rst_addr_wdata", {bus.bus_addr, bus.bus_wdata}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_one($sformatf("vec%0d", i), vecs[i].dm, vecs[i].ds, vecs[i].am, vecs[i].asv,
                    vecs[i].fk, vecs[i].fkk, -1, vecs[i].edone, vecs[i].ecode, vecs[i].eidx);

        // Negative ADC offset at k=7 must reach the bus sign-extended
        run_one("neg", vecs[1].dm, vecs[1].ds, vecs[1].am, vecs[1].asv, 0, 0, -1, 1'b1, 2'd0, 8'd0);
        chk("neg_wdata7", wlog[7], 64'h0000001C_FFFF8000);
        chk("neg_rdaddr7", 64'(rlog[7]), 64'h1C);
        run_one("base", vecs[0].dm, vecs[0].ds, vecs[0].am, vecs[0].asv, 0, 0, -1, 1'b1, 2'd0, 8'd0);
        chk("base_wdata0", wlog[0], 64'h00000000_00001000);

        run_one("restart", vecs[0].dm, vecs[0].ds, vecs[0].am, vecs[0].asv, 0, 0, 6, 1'b1, 2'd0, 8'd0);
        chk("restart_count", 64'(wlog.size() + rlog.size()), 64'd16);

        for (int r = 0; r < 20; r++) begin
            dm = 28'($urandom); ds = 28'($urandom); am = $urandom; asv = $urandom;
            fk = $urandom_range(0, 5); fkk = $urandom_range(0, 7);
            model(dm, ds, am, asv, fk, fkk, rdone, rcode, ridx, rcyc);
            run_one($sformatf("rnd%0d", r), dm, ds, am, asv, fk, fkk, -1, rdone, rcode, ridx);
        end

        // Reset while waiting on read k=2, then a late ack after reset
        fault_kind = 5; fault_k = 2;
        cfg_dm = vecs[0].dm; cfg_ds = vecs[0].ds; cfg_am = vecs[0].am; cfg_as = vecs[0].asv;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (bus.bus_ren && bus.bus_addr == 32'h8) found = 1'b1;
            else @(negedge clk);
        end
        chk("rst_mid_found", 64'(found), 64'd1);
        @(negedge clk); #1; rst = 1'b1; slave_off = 1'b1;
        @(negedge clk); #1; rst = 1'b0; force_ack = 1'b1; s0 = strobes;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_out%0d", i), 64'({busy, done, fail, fail_code, fail_idx, bus.bus_wen, bus.bus_ren}), 64'd0);
            chk($sformatf("rst_mid_bus%0d", i), {bus.bus_addr, bus.bus_wdata}, 64'd0);
            if (i == 0) begin #1; force_ack = 1'b0; end
        end
        chk("rst_mid_nostrobe", 64'(strobes - s0), 64'd0);
        slave_off = 1'b0;
        @(negedge clk);
        run_one("recover", vecs[6].dm, vecs[6].ds, vecs[6].am, vecs[6].asv, 0, 0, -1, 1'b1, 2'd0, 8'd0);

        chk("wen_ren_overlap", 64'(overlap), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
